// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD
// converter.
//   state_t     : converter state (IDLE / CONV / DONE)
//   ADD3_THRESH : digit value above which the double-dabble correction applies
//   ADD3_VAL    : correction added to such a digit before the shift
//   cnt_width() : width of the bit counter for a given binary input width
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] ADD3_THRESH = 4'd4;
   localparam logic [3:0] ADD3_VAL    = 4'd3;

   // Counter holds BIN_W-1 down to 0; never narrower than one bit.
   function automatic int cnt_width(input int bin_w);
      return (bin_w <= 2) ? 1 : $clog2(bin_w);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational double-dabble correction for one BCD digit.
// A digit greater than four gets three added so that the following left
// shift carries correctly into the next decimal digit.
//   din  : current BCD digit
//   dout : corrected digit, ready to be shifted
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din > ADD3_THRESH) ? (din + ADD3_VAL) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3), one input
// bit per clock, with valid/ready handshakes on both sides.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input word valid      in_ready : converter idle
//   in_bin     : binary input word     in_signed: treat in_bin as two's complement
//   out_valid  : result valid, held until out_ready
//   out_ready  : consumer accepts result
//   out_bcd    : BCD magnitude, digit i at [4i+3:4i]
//   out_neg    : result negative (signed mode only)
//   out_ovf    : magnitude did not fit in DIGITS digits (out_bcd is mod 10^DIGITS)
//   out_blank  : bit i set when digits i..DIGITS-1 are all zero (bit 0 always 0)
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 13,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      in_bin,
   input  logic                  in_signed,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_neg,
   output logic                  out_ovf,
   output logic [DIGITS-1:0]     out_blank
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = cnt_width(BIN_W);

   state_t                   state;
   logic [BIN_W-1:0]         mag;
   logic [BCD_W-1:0]         bcd;
   logic [CNT_W-1:0]         cnt;
   logic                     neg;
   logic                     ovf;

   logic signed [BIN_W-1:0]  in_s;
   logic                     in_neg;
   logic [BIN_W-1:0]         in_mag;

   logic [BCD_W-1:0]         bcd_adj;
   logic [BCD_W-1:0]         bcd_nxt;
   logic                     ovf_nxt;
   logic [DIGITS-1:0]        blank_nxt;
   logic                     upper_zero;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Magnitude of a negative input: the most negative value negates to
   // itself, whose unsigned reading is exactly 2^(BIN_W-1).
   assign in_s   = $signed(in_bin);
   assign in_neg = in_signed & in_bin[BIN_W-1];
   assign in_mag = in_neg ? $unsigned(-in_s) : in_bin;

   // Add-3 correction on every digit, then one left shift of {bcd, mag}.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (bcd[4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

   assign bcd_nxt = {bcd_adj[BCD_W-2:0], mag[BIN_W-1]};
   // The bit leaving the top digit is worth 10^DIGITS; losing it is overflow.
   assign ovf_nxt = ovf | bcd_adj[BCD_W-1];

   // Leading-zero mask: scan from the top digit down, stop at digit 1.
   always_comb begin
      blank_nxt  = '0;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         upper_zero   = upper_zero & (bcd_nxt[4*i +: 4] == 4'd0);
         blank_nxt[i] = upper_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mag       <= '0;
         bcd       <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         out_bcd   <= '0;
         out_neg   <= 1'b0;
         out_ovf   <= 1'b0;
         out_blank <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  neg   <= in_neg;
                  mag   <= in_mag;
                  bcd   <= '0;
                  cnt   <= CNT_W'(BIN_W - 1);
                  ovf   <= 1'b0;
                  state <= CONV;
               end
            end
            CONV: begin
               bcd <= bcd_nxt;
               mag <= {mag[BIN_W-2:0], 1'b0};
               ovf <= ovf_nxt;
               cnt <= cnt - CNT_W'(1);
               // Last bit: publish the final values straight from the shift.
               if (cnt == '0) begin
                  out_bcd   <= bcd_nxt;
                  out_neg   <= neg;
                  out_ovf   <= ovf_nxt;
                  out_blank <= blank_nxt;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: bench for bin2bcd_seq with a 13-bit and a 16-bit instance
// (both 4 digits). Table vectors, randomized words against an arithmetic
// reference model, backpressure and mid-conversion reset sequences.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst;

   logic        va, ra, sa, ova, ora, nega, ovfa;
   logic [12:0] bin_a;
   logic [15:0] bcd_a;
   logic [3:0]  blka;

   logic        vb, rb, sb, ovb, orb, negb, ovfb;
   logic [15:0] bin_b;
   logic [15:0] bcd_b;
   logic [3:0]  blkb;

   logic        sel;
   logic        drv_valid, drv_sgn, drv_ordy;
   logic [15:0] drv_bin;

   logic        c_in_ready, c_out_valid, c_neg, c_ovf;
   logic [15:0] c_bcd;
   logic [3:0]  c_blank;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign va    = !sel & drv_valid;
   assign ora   = !sel & drv_ordy;
   assign bin_a = drv_bin[12:0];
   assign sa    = drv_sgn;
   assign vb    = sel & drv_valid;
   assign orb   = sel & drv_ordy;
   assign bin_b = drv_bin;
   assign sb    = drv_sgn;

   assign c_in_ready  = sel ? rb   : ra;
   assign c_out_valid = sel ? ovb  : ova;
   assign c_bcd       = sel ? bcd_b : bcd_a;
   assign c_neg       = sel ? negb : nega;
   assign c_ovf       = sel ? ovfb : ovfa;
   assign c_blank     = sel ? blkb : blka;

   bin2bcd_seq #(.BIN_W(13), .DIGITS(4)) ua (
      .clk(clk), .rst(rst),
      .in_valid(va), .in_ready(ra), .in_bin(bin_a), .in_signed(sa),
      .out_valid(ova), .out_ready(ora), .out_bcd(bcd_a),
      .out_neg(nega), .out_ovf(ovfa), .out_blank(blka)
   );

   bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) ub (
      .clk(clk), .rst(rst),
      .in_valid(vb), .in_ready(rb), .in_bin(bin_b), .in_signed(sb),
      .out_valid(ovb), .out_ready(orb), .out_bcd(bcd_b),
      .out_neg(negb), .out_ovf(ovfb), .out_blank(blkb)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: decimal digits by division, overflow by comparison.
   task automatic model(input int w, input logic [15:0] bin, input logic sgn,
                        output logic [15:0] e_bcd, output logic e_neg,
                        output logic e_ovf, output logic [3:0] e_blank);
      longint v, mag, m, div;
      v     = longint'(bin) % (longint'(1) << w);
      e_neg = sgn && (((v >> (w - 1)) & 1) == 1);
      mag   = e_neg ? ((longint'(1) << w) - v) : v;
      e_ovf = (mag > 9999);
      m     = mag % 10000;
      e_bcd = '0;
      e_blank = '0;
      div   = 1;
      for (int d = 0; d < 4; d++) begin
         e_bcd[4*d +: 4] = 4'((m / div) % 10);
         if (d > 0) e_blank[d] = ((m / div) == 0);
         div = div * 10;
      end
   endtask

   task automatic run(input logic s, input logic [15:0] bin, input logic sgn,
                      input logic [15:0] e_bcd, input logic e_neg, input logic e_ovf,
                      input logic [3:0] e_blank, input int hold, input string tag);
      int lat;
      int w;
      sel = s;
      w   = s ? 16 : 13;
      @(negedge clk);
      chk({tag, " idle_ready"}, c_in_ready, 1);
      drv_valid = 1'b1;
      drv_bin   = bin;
      drv_sgn   = sgn;
      drv_ordy  = 1'b0;
      @(negedge clk);
      chk({tag, " busy_ready"}, c_in_ready, 0);
      lat = 0;
      // Inputs wander during conversion; they must not disturb the result.
      while (!c_out_valid && lat < 200) begin
         drv_valid = 1'($urandom % 2);
         drv_bin   = 16'($urandom);
         drv_sgn   = 1'($urandom % 2);
         @(negedge clk);
         lat++;
      end
      drv_valid = 1'b0;
      chk({tag, " latency"}, 64'(lat), 64'(w));
      chk({tag, " bcd"},   c_bcd,   e_bcd);
      chk({tag, " neg"},   c_neg,   e_neg);
      chk({tag, " ovf"},   c_ovf,   e_ovf);
      chk({tag, " blank"}, c_blank, e_blank);
      for (int h = 0; h < hold; h++) begin
         drv_valid = 1'b1;
         drv_bin   = 16'($urandom);
         @(negedge clk);
         chk({tag, " hold_valid"}, c_out_valid, 1);
         chk({tag, " hold_ready"}, c_in_ready, 0);
         chk({tag, " hold_bcd"},   {c_bcd, c_neg, c_ovf, c_blank},
                                   {e_bcd, e_neg, e_ovf, e_blank});
      end
      drv_valid = 1'b0;
      drv_ordy  = 1'b1;
      @(negedge clk);
      drv_ordy  = 1'b0;
      chk({tag, " ack_valid"}, c_out_valid, 0);
      chk({tag, " ack_ready"}, c_in_ready, 1);
      chk({tag, " ack_keep"},  {c_bcd, c_neg, c_ovf, c_blank},
                               {e_bcd, e_neg, e_ovf, e_blank});
   endtask

   typedef struct {
      logic        s;
      logic [15:0] bin;
      logic        sgn;
      logic [15:0] bcd;
      logic        neg;
      logic        ovf;
      logic [3:0]  blank;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] e_bcd;
      logic        e_neg, e_ovf;
      logic [3:0]  e_blank;
      logic [15:0] rb_bin;
      logic        rb_sgn;

      tbl[0]  = '{1'b0, 16'd8191,   1'b0, 16'h8191, 1'b0, 1'b0, 4'b0000};
      tbl[1]  = '{1'b0, 16'd0,      1'b0, 16'h0000, 1'b0, 1'b0, 4'b1110};
      tbl[2]  = '{1'b0, 16'd42,     1'b0, 16'h0042, 1'b0, 1'b0, 4'b1100};
      tbl[3]  = '{1'b0, 16'h1FFF,   1'b1, 16'h0001, 1'b1, 1'b0, 4'b1110};
      tbl[4]  = '{1'b0, 16'h1000,   1'b1, 16'h4096, 1'b1, 1'b0, 4'b0000};
      tbl[5]  = '{1'b0, 16'h1000,   1'b0, 16'h4096, 1'b0, 1'b0, 4'b0000};
      tbl[6]  = '{1'b0, 16'd0,      1'b1, 16'h0000, 1'b0, 1'b0, 4'b1110};
      tbl[7]  = '{1'b1, 16'd65535,  1'b0, 16'h5535, 1'b0, 1'b1, 4'b0000};
      tbl[8]  = '{1'b1, 16'd9999,   1'b0, 16'h9999, 1'b0, 1'b0, 4'b0000};
      tbl[9]  = '{1'b1, 16'h8000,   1'b1, 16'h2768, 1'b1, 1'b1, 4'b0000};
      tbl[10] = '{1'b1, 16'hFFFF,   1'b1, 16'h0001, 1'b1, 1'b0, 4'b1110};
      tbl[11] = '{1'b1, 16'd10000,  1'b0, 16'h0000, 1'b0, 1'b1, 4'b1110};

      sel = 1'b0; drv_valid = 1'b0; drv_sgn = 1'b0; drv_ordy = 1'b0; drv_bin = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst a_ready", ra, 1);
      chk("rst a_outs", {ova, bcd_a, nega, ovfa, blka}, 0);
      chk("rst b_ready", rb, 1);
      chk("rst b_outs", {ovb, bcd_b, negb, ovfb, blkb}, 0);
      rst = 1'b0;

      // Table vectors; entry 2 also sits in DONE under backpressure.
      for (int i = 0; i < 12; i++) begin
         run(tbl[i].s, tbl[i].bin, tbl[i].sgn, tbl[i].bcd, tbl[i].neg,
             tbl[i].ovf, tbl[i].blank, (i == 2) ? 10 : 0, $sformatf("vec%0d", i));
      end

      // Randomized words against the reference model.
      for (int i = 0; i < 30; i++) begin
         rb_bin = 16'($urandom) & 16'h1FFF;
         rb_sgn = 1'($urandom % 2);
         model(13, rb_bin, rb_sgn, e_bcd, e_neg, e_ovf, e_blank);
         run(1'b0, rb_bin, rb_sgn, e_bcd, e_neg, e_ovf, e_blank,
             int'($urandom % 3), $sformatf("rnd13_%0d", i));
      end
      for (int i = 0; i < 20; i++) begin
         rb_bin = (i % 4 == 0) ? 16'(9990 + $urandom % 20) : 16'($urandom);
         rb_sgn = 1'($urandom % 2);
         model(16, rb_bin, rb_sgn, e_bcd, e_neg, e_ovf, e_blank);
         run(1'b1, rb_bin, rb_sgn, e_bcd, e_neg, e_ovf, e_blank,
             int'($urandom % 3), $sformatf("rnd16_%0d", i));
      end

      // Reset in the middle of a conversion, with old results still showing.
      run(1'b0, 16'd8191, 1'b0, 16'h8191, 1'b0, 1'b0, 4'b0000, 0, "pre_rst");
      sel = 1'b0;
      @(negedge clk);
      drv_valid = 1'b1; drv_bin = 16'd777; drv_sgn = 1'b0;
      @(negedge clk);
      drv_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("midconv busy", ra, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst a_ready", ra, 1);
      chk("midrst a_outs", {ova, bcd_a, nega, ovfa, blka}, 0);
      chk("midrst b_outs", {ovb, bcd_b, negb, ovfb, blkb}, 0);
      run(1'b0, 16'd1234, 1'b0, 16'h1234, 1'b0, 1'b0, 4'b0000, 0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. Adds a valid/ready handshake on both sides, optional two's-complement input, overflow detection and a leading-zero blank mask. Feeds the seven-segment and display paths of the CPU, replacing the fixed 13-bit free-running converter.

Parameters:
BIN_W, 13, binary input width (>=2)
DIGITS, 4, number of BCD output digits (>=1); output width 4*DIGITS

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input word valid
in_ready  out  1  converter idle, can accept a word
in_bin  in  BIN_W  binary input
in_signed  in  1  treat in_bin as two's complement (sampled with in_bin)
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
out_bcd  out  4*DIGITS  BCD magnitude; digit i at [4i+3:4i]
out_neg  out  1  result negative (signed mode, MSB set)
out_ovf  out  1  magnitude exceeds 10^DIGITS-1
out_blank  out  DIGITS  bit i set: digit i is a leading zero (bit 0 always 0)

Behaviour:
- States: IDLE, CONV, DONE. Reset -> IDLE; out_valid=0, out_bcd=0, out_neg=0, out_ovf=0, out_blank=0, internal shift/BCD regs and bit counter = 0.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- IDLE: on in_valid=1, capture at edge: neg = in_signed & in_bin[BIN_W-1]; magnitude = neg ? -in_bin : in_bin (BIN_W bits unsigned; -2^(BIN_W-1) maps to 2^(BIN_W-1) exactly); BCD working reg cleared; counter = BIN_W-1; ovf flag cleared; -> CONV.
- CONV, each edge: every digit >4 gets +3, then {bcd, mag} shifted left 1 in the same cycle (combined adjust+shift). Bit shifted out of the top digit sets sticky ovf. Counter decrements; at counter==0 edge -> DONE and out_bcd/out_neg/out_ovf/out_blank registered from the final values.
- Latency: acceptance edge = edge 0; out_valid high after edge BIN_W. Min throughput: one word per BIN_W+2 cycles.
- DONE: outputs held stable while out_ready=0. On out_ready=1, -> IDLE at that edge; outputs keep last values (out_valid drops).
- Overflow: out_bcd = magnitude mod 10^DIGITS (lower digits remain correct); out_ovf=1.
- Blank mask: bit i (i>=1) = 1 iff digits i..DIGITS-1 are all zero. Zero input: out_bcd=0, out_blank = all ones except bit 0, out_neg=0.
- in_valid while not IDLE: ignored, no capture; in_bin/in_signed may change freely during CONV.
- out_neg never set when in_signed=0, regardless of MSB.
- rst asserted in any state, including mid-CONV or in DONE: next edge returns to reset values; in-flight word discarded.

Decomposition:
- Package bin2bcd_pkg: state enum (IDLE/CONV/DONE), ADD3_THRESH=4'd4, ADD3_VAL=4'd3, function for bit-counter width clog2(BIN_W).
- Sub-module bcd_digit_adj: combinational 4-bit "if >4 add 3" cell, instantiated DIGITS times via generate.

Test Plan:
- Default params, in_bin=8191 unsigned, out_ready=1 -> out_valid exactly 13 edges after accept, out_bcd=16'h8191, ovf=0, blank=4'b0000.
- in_bin=0 -> out_bcd=0, blank=4'b1110, neg=0; in_bin=42 -> out_bcd=16'h0042, blank=4'b1100.
- in_signed=1, in_bin=13'h1FFF (-1) -> bcd=16'h0001, neg=1; in_bin=13'h1000 -> bcd=16'h4096, neg=1; same value with in_signed=0 -> bcd=16'h4096, neg=0.
- BIN_W=16, DIGITS=4, in_bin=65535 -> out_ovf=1, out_bcd=16'h5535; in_bin=9999 -> ovf=0, bcd=16'h9999.
- Backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge, next word accepted.
- rst pulsed mid-CONV (cycle 5) -> all outputs 0, in_ready=1 next cycle; fresh conversion of 1234 gives 16'h1234.
